// File: rtl/vector_ping_pong_ctrl_if.sv
// Bus bundle between the ping-pong sequencer and its load source / cfg port.
// Carries the load stream (s_*), the cfg write port (cfg_*) and ping.
interface vector_ping_pong_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ADDR_WIDTH  = 5
);
    localparam int W = PARALLELISM * DATA_WIDTH;

    logic                  s_valid;
    logic                  s_ready;
    logic [W-1:0]          s_data;
    logic                  cfg_valid;
    logic                  cfg_write;
    logic                  cfg_ready;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [W-1:0]          cfg_wdata;
    logic                  cfg_en;
    logic                  ping;

    modport master (
        input  s_valid, s_data, cfg_ready,
        output s_ready, cfg_valid, cfg_write,
        output cfg_addr, cfg_wdata, cfg_en, ping
    );

    modport slave (
        output s_valid, s_data, cfg_ready,
        input  s_ready, cfg_valid, cfg_write,
        input  cfg_addr, cfg_wdata, cfg_en, ping
    );
endinterface

// File: rtl/vector_ping_pong_ctrl.sv
// Job sequencer for the vector ping-pong RAM pair: load, iterate, report.
// Ports: clk, rst_n (sync, active-low); i_start/i_abort/i_num_iters/
// i_init_bank job control; o_iter_start/i_iter_done engine handshake;
// o_iter_count, o_busy, o_done, o_result_bank status; bus (master) carries
// the load stream, cfg write port, cfg_en and ping.
// Optional: VECTOR_PING_PONG_CTRL_PERF_EN adds o_perf_load_cycles and
// o_perf_run_cycles saturating cycle counters.
module vector_ping_pong_ctrl #(
    parameter int   LENGTH      = 32,
    parameter int   DATA_WIDTH  = 32,
    parameter int   PARALLELISM = 4,
    parameter int   MAX_ITERS   = 255,
    localparam int  ITER_WIDTH  = $clog2(MAX_ITERS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ITER_WIDTH-1:0] i_num_iters,
    input  logic                  i_init_bank,
    output logic                  o_iter_start,
    input  logic                  i_iter_done,
    output logic [ITER_WIDTH-1:0] o_iter_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_result_bank,
`ifdef VECTOR_PING_PONG_CTRL_PERF_EN
    output logic [31:0]           o_perf_load_cycles,
    output logic [31:0]           o_perf_run_cycles,
`endif
    vector_ping_pong_ctrl_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(LENGTH);
    localparam int BEATS      = LENGTH / PARALLELISM;
    localparam int W          = PARALLELISM * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ITER_WIDTH-1:0] r_num_iters;
    logic [ITER_WIDTH-1:0] r_iter_count;
    logic [ADDR_WIDTH-1:0] r_cfg_addr;
    logic                  r_ping;
    logic                  r_result_bank;

    logic                  w_accept;
    logic                  w_beat;
    logic                  w_step;
    logic                  w_cfg_en;
    logic                  w_last;
    logic [ITER_WIDTH-1:0] w_iter_inc;

    // Base address of the final beat of the vector.
    assign w_last     = r_cfg_addr ==
                        ADDR_WIDTH'((BEATS - 1) * PARALLELISM);
    assign w_iter_inc = r_iter_count + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over beat completion and iter_done in every busy state.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;
        w_step       = 1'b0;
        w_cfg_en     = 1'b0;
        o_iter_start = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_cfg_en = 1'b1;
                    if (bus.s_valid && bus.cfg_ready) begin
                        w_beat = 1'b1;
                        if (w_last) begin
                            w_next = (r_num_iters != '0) ? S_RUN : S_FIN;
                        end
                    end
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    o_iter_start = 1'b1;
                    w_next       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (i_iter_done) begin
                    w_step = 1'b1;
                    w_next = (w_iter_inc == r_num_iters) ? S_FIN : S_RUN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
                o_done = !i_abort;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num_iters   <= '0;
            r_iter_count  <= '0;
            r_cfg_addr    <= '0;
            r_ping        <= 1'b0;
            r_result_bank <= 1'b0;
        end else begin
            if (w_accept) begin
                r_num_iters  <= i_num_iters;
                r_iter_count <= '0;
                r_cfg_addr   <= '0;
                r_ping       <= i_init_bank;
            end
            if (w_beat) begin
                r_cfg_addr <= w_last ? '0 :
                              r_cfg_addr + ADDR_WIDTH'(PARALLELISM);
            end
            if (w_step) begin
                r_ping       <= ~r_ping;
                r_iter_count <= w_iter_inc;
            end
            if (o_done) begin
                r_result_bank <= r_ping;
            end
        end
    end

`ifdef VECTOR_PING_PONG_CTRL_PERF_EN
    logic [31:0] r_perf_load;
    logic [31:0] r_perf_run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_load <= '0;
            r_perf_run  <= '0;
        end else if (w_accept) begin
            r_perf_load <= '0;
            r_perf_run  <= '0;
        end else begin
            if (r_state == S_LOAD && r_perf_load != '1) begin
                r_perf_load <= r_perf_load + 32'd1;
            end
            if ((r_state == S_RUN || r_state == S_WAIT) &&
                r_perf_run != '1) begin
                r_perf_run <= r_perf_run + 32'd1;
            end
        end
    end

    assign o_perf_load_cycles = r_perf_load;
    assign o_perf_run_cycles  = r_perf_run;
`endif

    // Result is visible in the done cycle itself, then held.
    assign o_result_bank = o_done ? r_ping : r_result_bank;
    assign o_iter_count  = r_iter_count;
    assign o_busy        = r_state != S_IDLE;

    assign bus.cfg_en    = w_cfg_en;
    assign bus.s_ready   = w_cfg_en & bus.cfg_ready;
    assign bus.cfg_valid = w_cfg_en & bus.s_valid;
    assign bus.cfg_write = w_cfg_en & bus.s_valid;
    assign bus.cfg_wdata = w_cfg_en ? bus.s_data : {W{1'b0}};
    assign bus.cfg_addr  = r_cfg_addr;
    assign bus.ping      = r_ping;
endmodule
